// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles four little-endian stream bytes into one 32-bit instruction word.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    // The byte counter doubles as the lane select, so the first byte lands in [7:0].
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_accept) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt                        <= r_cnt + 2'd1;
        end
    end

    assign o_word      = r_word;
    assign o_word_done = i_accept && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, holding the core in reset until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        ByteValid,
    input  logic [7:0]  ByteData,
    output logic        ByteReady,
    output logic        WriteEnable,
    output logic [31:0] WriteAddress,
    output logic [31:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Overflow,
    output logic        CpuReset
);

    localparam logic [32:0] CAP = 33'd1 << ADD;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_index;
    logic [7:0]         r_cnt_lo;
    logic               r_overflow;

    logic               w_ready;
    logic               w_accept;
    logic               w_data_accept;
    logic               w_start_ok;
    logic               w_word_done;
    logic [CNT_W-1:0]   w_count_in;
    logic               w_last;
    logic               w_in_cap;
    logic [31:0]        w_word;

    assign w_ready       = (r_state == S_CNT_LO) || (r_state == S_CNT_HI) || (r_state == S_DATA);
    assign w_accept      = ByteValid && w_ready;
    assign w_data_accept = w_accept && (r_state == S_DATA);
    assign w_start_ok    = Start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_count_in    = {ByteData, r_cnt_lo};
    assign w_last        = ({1'b0, r_index} + 17'd1) == {1'b0, r_count};
    assign w_in_cap      = {17'b0, r_index} < CAP;

    imem_loader_byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start_ok),
        .i_accept    (w_data_accept),
        .i_byte      (ByteData),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        CpuReset    = 1'b1;
        WriteEnable = 1'b0;
        case (r_state)
            S_IDLE:   if (Start) w_next = S_CNT_LO;
            S_CNT_LO: begin
                Busy = 1'b1;
                if (ByteValid) w_next = S_CNT_HI;
            end
            S_CNT_HI: begin
                Busy = 1'b1;
                if (ByteValid) w_next = (w_count_in == '0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
                Busy = 1'b1;
                if (w_word_done) w_next = S_WRITE;
            end
            S_WRITE: begin
                Busy        = 1'b1;
                WriteEnable = w_in_cap;
                w_next      = w_last ? S_DONE : S_DATA;
            end
            S_DONE: begin
                Done     = 1'b1;
                CpuReset = 1'b0;
                if (Start) w_next = S_CNT_LO;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_index    <= '0;
            r_cnt_lo   <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_count    <= '0;
            r_index    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == S_CNT_LO && w_accept) r_cnt_lo <= ByteData;
            if (r_state == S_CNT_HI && w_accept) begin
                r_count <= w_count_in;
                if ({17'b0, w_count_in} > CAP) r_overflow <= 1'b1;
            end
            // Out-of-range words still advance the index so the stream stays aligned.
            if (r_state == S_WRITE) r_index <= r_index + 16'd1;
        end
    end

    assign ByteReady    = w_ready;
    assign WriteAddress = {14'b0, r_index, 2'b00};
    assign WriteData    = w_word;
    assign Overflow     = r_overflow;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (instantiated with a 4-word capacity).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Start = 1'b0;
    logic        ByteValid = 1'b0;
    logic [7:0]  ByteData = 8'h00;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic        CpuReset;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned ready_in_write = 0;
    logic [31:0] wa [$];
    logic [31:0] wd [$];

    imem_loader #(.ADD(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .ByteValid    (ByteValid),
        .ByteData     (ByteData),
        .ByteReady    (ByteReady),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .Busy         (Busy),
        .Done         (Done),
        .Overflow     (Overflow),
        .CpuReset     (CpuReset)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (WriteEnable) begin
            wa.push_back(WriteAddress);
            wd.push_back(WriteData);
            if (ByteReady) ready_in_write++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n = 0;
        ByteValid = 1'b0;
        repeat (gap) tick();
        ByteValid = 1'b1;
        ByteData  = b;
        while (!ByteReady && n < 50) begin
            tick();
            n++;
        end
        if (!ByteReady) chk("byte_ready_timeout", 32'(ByteReady), 32'd1);
        tick();
        ByteValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic check_write(input string tag, input int unsigned i,
                               input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_addr"}, (wa.size() > i) ? wa[i] : 32'hxxxxxxxx, addr);
        chk({tag, "_data"}, (wd.size() > i) ? wd[i] : 32'hxxxxxxxx, data);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ByteReady), 32'd0);
        chk({tag, "_we"},    32'(WriteEnable), 32'd0);
        chk({tag, "_waddr"}, WriteAddress, 32'd0);
        chk({tag, "_wdata"}, WriteData, 32'd0);
        chk({tag, "_busy"},  32'(Busy), 32'd0);
        chk({tag, "_done"},  32'(Done), 32'd0);
        chk({tag, "_ovf"},   32'(Overflow), 32'd0);
        chk({tag, "_cpurst"}, 32'(CpuReset), 32'd1);
    endtask

    initial begin
        logic [7:0] basic [10];
        int unsigned gaps [10];
        basic = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        gaps  = '{1, 0, 2, 0, 3, 1, 0, 2, 1, 4};

        // Power-up reset
        tick();
        tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();
        chk("idle_cpurst", 32'(CpuReset), 32'd1);
        ByteValid = 1'b1;
        ByteData  = 8'hFF;
        tick();
        chk("idle_ignores_byte", 32'(ByteReady), 32'd0);
        ByteValid = 1'b0;

        // Basic load
        pulse_start();
        chk("start_ready", 32'(ByteReady), 32'd1);
        chk("start_busy", 32'(Busy), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(basic[i], 0);
        chk("w1_we", 32'(WriteEnable), 32'd1);
        chk("w1_ready", 32'(ByteReady), 32'd0);
        chk("w1_addr", WriteAddress, 32'd4);
        chk("w1_data", WriteData, 32'h00200593);
        tick();
        chk("basic_done", 32'(Done), 32'd1);
        chk("basic_busy", 32'(Busy), 32'd0);
        chk("basic_cpurst", 32'(CpuReset), 32'd0);
        chk("basic_nwr", wa.size(), 32'd2);
        check_write("basic_w0", 0, 32'd0, 32'h00100513);
        check_write("basic_w1", 1, 32'd4, 32'h00200593);
        wa.delete();
        wd.delete();

        // Same stream with gaps in ByteValid
        pulse_start();
        chk("restart_done_clr", 32'(Done), 32'd0);
        chk("restart_cpurst", 32'(CpuReset), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(basic[i], gaps[i]);
        tick();
        chk("gap_done", 32'(Done), 32'd1);
        chk("gap_nwr", wa.size(), 32'd2);
        check_write("gap_w0", 0, 32'd0, 32'h00100513);
        check_write("gap_w1", 1, 32'd4, 32'h00200593);
        chk("ready_in_write", ready_in_write, 32'd0);
        wa.delete();
        wd.delete();

        // Zero count
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("zero_done", 32'(Done), 32'd1);
        chk("zero_busy", 32'(Busy), 32'd0);
        chk("zero_cpurst", 32'(CpuReset), 32'd0);
        tick();
        chk("zero_nwr", wa.size(), 32'd0);

        // Overflow: N = 5 with a 4-word memory
        pulse_start();
        send_byte(8'h05, 0);
        chk("ovf_pre", 32'(Overflow), 32'd0);
        send_byte(8'h00, 0);
        chk("ovf_set", 32'(Overflow), 32'd1);
        for (int k = 0; k < 5; k++) begin
            send_byte(8'hA0 + 8'(k), 0);
            send_byte(8'hB0, 0);
            send_byte(8'hC0, 0);
            send_byte(8'hD0, 0);
        end
        chk("ovf_w4_we", 32'(WriteEnable), 32'd0);
        chk("ovf_w4_busy", 32'(Busy), 32'd1);
        tick();
        chk("ovf_done", 32'(Done), 32'd1);
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        chk("ovf_nwr", wa.size(), 32'd4);
        check_write("ovf_w0", 0, 32'd0,  32'hD0C0B0A0);
        check_write("ovf_w1", 1, 32'd4,  32'hD0C0B0A1);
        check_write("ovf_w2", 2, 32'd8,  32'hD0C0B0A2);
        check_write("ovf_w3", 3, 32'd12, 32'hD0C0B0A3);
        wa.delete();
        wd.delete();

        // Start while busy is ignored
        pulse_start();
        chk("ovf_clr", 32'(Overflow), 32'd0);
        chk("ovf_restart_done", 32'(Done), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        tick();
        send_byte(8'h55, 0);
        pulse_start();
        chk("busy_start_ready", 32'(ByteReady), 32'd1);
        chk("busy_start_busy", 32'(Busy), 32'd1);
        chk("busy_start_addr", WriteAddress, 32'd4);
        send_byte(8'h66, 0);
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        tick();
        chk("busy_start_done", 32'(Done), 32'd1);
        chk("busy_start_nwr", wa.size(), 32'd2);
        check_write("busy_w0", 0, 32'd0, 32'h44332211);
        check_write("busy_w1", 1, 32'd4, 32'h88776655);

        // Reset after the 6th data byte
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i), 0);
        reset = 1'b1;
        tick();
        check_reset_outputs("midrst");
        reset = 1'b0;
        wa.delete();
        wd.delete();
        tick();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        tick();
        chk("reload_done", 32'(Done), 32'd1);
        chk("reload_nwr", wa.size(), 32'd1);
        check_write("reload_w0", 0, 32'd0, 32'h12345678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
